// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IDLE/FETCH/WAIT request FSM, IF/ID register,
// and immediate-format flags decoded from the registered instruction.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        take_branch,
  input  logic [63:0] branch_pc,
  input  logic [63:0] branch_offset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] ibus,
  output logic [63:0] if_pc,
  output logic        id_valid,
  output logic        i_type,
  output logic        d_type,
  output logic        b_type,
  output logic        cb_type,
  output logic        iw_type
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n, if_pc_n;
  logic [31:0] ibus_n;
  logic        vld_n, accept;

  assign imem_req  = (state != IDLE);
  assign imem_addr = pc;
  assign accept    = imem_req & imem_ready & ~stall & ~take_branch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      ibus     <= '0;
      if_pc    <= '0;
      id_valid <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ibus     <= ibus_n;
      if_pc    <= if_pc_n;
      id_valid <= vld_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ibus_n  = ibus;
    if_pc_n = if_pc;
    vld_n   = id_valid;
    if (take_branch) begin
      // Redirect wins over stall and any same-cycle memory response.
      pc_n    = (branch_pc + branch_offset) & ~64'd3;
      vld_n   = 1'b0;
      state_n = FETCH;
    end else if (state == IDLE) begin
      state_n = FETCH;
      if (!stall) vld_n = 1'b0;
    end else if (stall) begin
      state_n = state;
    end else if (accept) begin
      ibus_n  = imem_data;
      if_pc_n = pc;
      vld_n   = 1'b1;
      pc_n    = pc + 64'd4;
      state_n = FETCH;
    end else begin
      vld_n   = 1'b0;
      state_n = WAIT;
    end
  end

  // Opcode prefixes are mutually exclusive, so at most one flag can assert.
  always_comb begin
    b_type  = 1'b0;
    cb_type = 1'b0;
    iw_type = 1'b0;
    i_type  = 1'b0;
    d_type  = 1'b0;
    if (id_valid) begin
      b_type  = (ibus[31:26] == 6'b000101) || (ibus[31:26] == 6'b100101);
      cb_type = (ibus[31:24] == 8'b10110100) || (ibus[31:24] == 8'b10110101);
      iw_type = (ibus[31:23] == 9'b110100101) || (ibus[31:23] == 9'b111100101);
      d_type  = (ibus[31:21] == 11'b11111000010) || (ibus[31:21] == 11'b11111000000);
      case (ibus[31:22])
        10'b1001000100, 10'b1011000100, 10'b1101000100, 10'b1111000100,
        10'b1001001000, 10'b1111001000, 10'b1011001000, 10'b1101001000:
          i_type = 1'b1;
        default: i_type = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level fetch model,
// preceded by a directed walk through the documented scenarios.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, take_branch, imem_ready;
  logic [63:0] branch_pc, branch_offset;
  logic [31:0] imem_data;
  logic        imem_req, id_valid, i_type, d_type, b_type, cb_type, iw_type;
  logic [63:0] imem_addr, if_pc;
  logic [31:0] ibus;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .take_branch(take_branch),
    .branch_pc(branch_pc), .branch_offset(branch_offset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_data(imem_data), .ibus(ibus), .if_pc(if_pc), .id_valid(id_valid),
    .i_type(i_type), .d_type(d_type), .b_type(b_type), .cb_type(cb_type),
    .iw_type(iw_type)
  );

  always #5 clk = ~clk;

  // Model: "idle" is the single post-reset cycle with no request; otherwise
  // the front end is always requesting instruction memory at m_pc.
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_ibus;
  logic        m_vld, m_idle, m_known;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Flags in order {i, d, b, cb, iw}.
  function automatic logic [4:0] ref_flags(input logic v, input logic [31:0] w);
    logic [9:0] i_ops [8] = '{10'h244, 10'h2C4, 10'h344, 10'h3C4,
                              10'h248, 10'h3C8, 10'h2C8, 10'h348};
    logic [4:0] f = '0;
    if (!v) return '0;
    foreach (i_ops[k]) if (w[31:22] == i_ops[k]) f[4] = 1'b1;
    f[3] = (w[31:21] == 11'h7C2) || (w[31:21] == 11'h7C0);
    f[2] = (w[31:26] == 6'h05)   || (w[31:26] == 6'h25);
    f[1] = (w[31:24] == 8'hB4)   || (w[31:24] == 8'hB5);
    f[0] = (w[31:23] == 9'h1A5)  || (w[31:23] == 9'h1E5);
    return f;
  endfunction

  task automatic check_outputs();
    chk("imem_req",  {63'd0, imem_req}, {63'd0, m_known & ~m_idle});
    chk("imem_addr", imem_addr, m_pc);
    chk("ibus",      {32'd0, ibus}, {32'd0, m_ibus});
    chk("if_pc",     if_pc, m_ifpc);
    chk("id_valid",  {63'd0, id_valid}, {63'd0, m_vld});
    chk("flags",     {59'd0, i_type, d_type, b_type, cb_type, iw_type},
                     {59'd0, ref_flags(m_vld, m_ibus)});
  endtask

  // One clock: check current outputs, apply inputs, advance the model.
  task automatic step(input logic r, input logic st, input logic tb_,
                      input logic [63:0] bpc, input logic [63:0] boff,
                      input logic rdy, input logic [31:0] data);
    @(negedge clk);
    if (m_known) check_outputs();
    reset = r; stall = st; take_branch = tb_; branch_pc = bpc;
    branch_offset = boff; imem_ready = rdy; imem_data = data;
    @(posedge clk);
    if (r) begin
      m_pc = '0; m_ibus = '0; m_ifpc = '0; m_vld = 1'b0; m_idle = 1'b1; m_known = 1'b1;
    end else if (tb_) begin
      m_pc = (bpc + boff) & ~64'd3; m_vld = 1'b0; m_idle = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (rdy) begin
      m_ibus = data; m_ifpc = m_pc; m_vld = 1'b1; m_pc = m_pc + 64'd4;
    end else begin
      m_vld = 1'b0;
    end
    #1;
  endtask

  task automatic go(input logic rdy, input logic [31:0] data);
    step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, rdy, data);
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 6))
      0: return {10'h244 | 10'(($urandom_range(0, 3)) << 7), r[21:0]};
      1: return {11'h7C2, r[20:0]};
      2: return {6'h05, r[25:0]};
      3: return {8'hB5, r[23:0]};
      4: return {9'h1E5, r[22:0]};
      default: return r;
    endcase
  endfunction

  localparam logic [31:0] ADDI = 32'h91000C21;
  localparam logic [31:0] BR   = 32'h17FFFFFF;
  localparam logic [31:0] LDUR = 32'hF8408020;

  initial begin
    m_known = 1'b0; m_idle = 1'b1;
    m_pc = '0; m_ibus = '0; m_ifpc = '0; m_vld = 1'b0;
    reset = 1'b1; stall = 1'b0; take_branch = 1'b0; imem_ready = 1'b0;
    branch_pc = '0; branch_offset = '0; imem_data = '0;

    // Reset, then an uninterrupted stream of three instructions.
    step(1'b1, 1'b1, 1'b1, 64'h100, 64'h40, 1'b1, ADDI);
    step(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 32'd0);
    chk("reset_req", {63'd0, imem_req}, 64'd0);
    go(1'b1, BR);
    chk("first_addr", imem_addr, 64'd0);
    go(1'b1, BR);
    chk("b_flag", {63'd0, b_type}, 64'd1);
    go(1'b1, LDUR);
    chk("d_flag", {63'd0, d_type}, 64'd1);
    go(1'b1, ADDI);
    chk("i_flag", {63'd0, i_type}, 64'd1);
    chk("if_pc_8", if_pc, 64'h8);
    // Stall two cycles with ready high: everything holds at 0xC.
    step(1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 1'b1, LDUR);
    step(1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 1'b1, LDUR);
    chk("stall_addr", imem_addr, 64'hC);
    chk("stall_ibus", {32'd0, ibus}, {32'd0, ADDI});
    go(1'b1, ADDI);
    // Three not-ready cycles at 0x10, then accept.
    go(1'b0, 32'd0); go(1'b0, 32'd0); go(1'b0, 32'd0);
    chk("wait_addr", imem_addr, 64'h10);
    chk("wait_vld", {63'd0, id_valid}, 64'd0);
    go(1'b1, BR);
    chk("after_wait", imem_addr, 64'h14);
    // Branch beats stall and a ready response.
    step(1'b0, 1'b1, 1'b1, 64'h40, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, ADDI);
    chk("br_pc", imem_addr, 64'h30);
    chk("br_vld", {63'd0, id_valid}, 64'd0);
    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'hE, 1'b0, 32'd0);
    chk("br_align", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    go(1'b1, ADDI);
    chk("wrap", imem_addr, 64'd0);
    // Reset while waiting on memory.
    go(1'b0, 32'd0); go(1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b1, 64'h80, 64'h8, 1'b1, ADDI);
    chk("rst_wait_req", {63'd0, imem_req}, 64'd0);
    chk("rst_wait_vld", {63'd0, id_valid}, 64'd0);
    go(1'b1, ADDI);
    chk("rst_refetch", {63'd0, imem_req}, 64'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] off;
      off = {{40{1'b0}}, 24'($urandom)} << 2;
      if ($urandom_range(0, 1) != 0) off = -off;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, {$urandom, $urandom},
           ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : off,
           $urandom_range(0, 9) < 7, rand_insn());
    end
    step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-high; sampled only on rising clk.
REQ-003 stall  in  1  decode stage cannot accept; hold PC and IF/ID register.
REQ-004 take_branch  in  1  execute resolved a taken branch this cycle.
REQ-005 branch_pc  in  64  PC of the taken branch instruction.
REQ-006 branch_offset  in  64  sign-extended, x4-scaled offset from the immediate extender.
REQ-007 imem_req  out  1  fetch request to instruction memory.
REQ-008 imem_addr  out  64  byte address of the requested instruction; equals pc.
REQ-009 imem_ready  in  1  imem_data valid for imem_addr this cycle.
REQ-010 imem_data  in  32  instruction word.
REQ-011 ibus  out  32  registered instruction to decode and extender.
REQ-012 if_pc  out  64  PC of the instruction on ibus.
REQ-013 id_valid  out  1  ibus/if_pc hold a real instruction.
REQ-014 i_type, d_type, b_type, cb_type, iw_type  out  1 each  immediate-format flags decoded from ibus; drive the extender directly.

Function
REQ-015 States: IDLE, FETCH, WAIT; encoding is free.
REQ-016 IDLE: imem_req=0; unconditional transition to FETCH next cycle.
REQ-017 FETCH/WAIT: imem_req=1, imem_addr=pc.
REQ-018 Accept condition: state in {FETCH, WAIT}, imem_ready=1, stall=0, take_branch=0.
REQ-019 On accept: ibus<=imem_data, if_pc<=pc, id_valid<=1, pc<=pc+4, state<=FETCH.
REQ-020 FETCH with imem_ready=0, take_branch=0: state<=WAIT.
REQ-021 Any cycle with stall=0, take_branch=0 and no accept: id_valid<=0 (bubble); ibus and if_pc hold.
REQ-022 stall=1, take_branch=0: pc, ibus, if_pc, id_valid and state all hold; imem_req stays 1 with unchanged imem_addr; a ready response that cycle is discarded and refetched.
REQ-023 take_branch=1 has priority over stall and imem_ready: pc<=(branch_pc+branch_offset) with bits [1:0] forced to 00, id_valid<=0, state<=FETCH; any same-cycle imem response is discarded.
REQ-024 take_branch in IDLE: pc redirected per REQ-023; state still goes to FETCH.
REQ-025 PC arithmetic is 64-bit unsigned, modulo 2^64: 0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
REQ-026 pc[1:0] is always 00.
REQ-027 Flags are combinational from ibus, gated by id_valid; all flags are 0 when id_valid=0; at most one flag is 1.
REQ-028 b_type: ibus[31:26] = 000101 (B) or 100101 (BL).
REQ-029 cb_type: ibus[31:24] = 10110100 (CBZ) or 10110101 (CBNZ).
REQ-030 iw_type: ibus[31:23] = 110100101 (MOVZ) or 111100101 (MOVK).
REQ-031 i_type: ibus[31:22] in {1001000100, 1011000100, 1101000100, 1111000100, 1001001000, 1111001000, 1011001000, 1101001000}.
REQ-032 d_type: ibus[31:21] = 11111000010 (LDUR) or 11111000000 (STUR).
REQ-033 Any other encoding: all flags 0 while id_valid stays 1.

Reset
REQ-034 reset=1 at a rising edge: pc=0, ibus=0, if_pc=0, id_valid=0, state=IDLE, imem_req=0; all flags 0.
REQ-035 reset overrides take_branch, stall and imem_ready in the same cycle.
REQ-036 Reset mid-WAIT discards the outstanding request; the first request after release is addr 0, issued two cycles after the last reset cycle.

Verification
REQ-037 Reset release, imem_ready=1 always, stall=0 -> imem_addr 0,4,8; if_pc follows one cycle later; id_valid=1 from the first accept onward.
REQ-038 imem_data=0x91000C21 (ADDI) accepted -> i_type=1, other flags 0; 0x17FFFFFF (B) -> b_type=1; 0xF8408020 (LDUR) -> d_type=1.
REQ-039 imem_ready low 3 cycles at addr 0x10 -> state WAIT, id_valid=0 for those cycles, imem_addr held at 0x10; accept on the 4th cycle, then pc=0x14.
REQ-040 stall=1 for 2 cycles with ibus=0x91000C21, if_pc=0x8 -> ibus, if_pc and id_valid unchanged, imem_addr held at 0xC.
REQ-041 take_branch=1, stall=1, imem_ready=1, branch_pc=0x40, branch_offset=0xFFFF_FFFF_FFFF_FFF0 -> next pc=0x30, id_valid=0, response discarded.
REQ-042 pc=0xFFFF_FFFF_FFFF_FFFC accepted -> pc=0; reset asserted during WAIT -> outputs match REQ-034 next cycle.
